// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM (one write, one registered read port) with a zero-fill sweep after reset.
// Optional macro DUAL_PORT_RAM_BYPASS_EN selects write-first forwarding on same-address read/write.
module dual_port_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] wr_add,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] rd_add,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  rd_valid,
    output logic                  busy
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  busy_q, busy_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_add;
        mem_wdata  = in;
        rd_word    = mem[rd_add];

        case (state_q)
            ST_INIT: begin
                // The sweep owns the write port; user requests are dropped.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                mem_we = wr;
                if (rd) begin
                    rd_valid_d = 1'b1;
                    out_d      = rd_word;
`ifdef DUAL_PORT_RAM_BYPASS_EN
                    if (wr && (wr_add == rd_add)) begin
                        out_d = in;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_READY;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_CLEAR ? ST_INIT : ST_READY;
            cnt_q      <= '0;
            out_q      <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= INIT_CLEAR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Array contents survive reset; only the sweep clears them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out      = out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: table vectors, hand-written reset/sweep sequences and random traffic
// checked against an array-based model of the RAM.
module tb_dual_port_ram;

`ifdef DUAL_PORT_RAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int DEPTH_C = 4096;
    localparam logic [63:0] COLL_EXP = BYPASS ? 64'h2222 : 64'h1111;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [11:0] wr_add;
    logic [63:0] wdata;
    logic        rd;
    logic [11:0] rd_add;
    logic [63:0] dout;
    logic        rd_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem [DEPTH_C];
    logic [63:0] model_out;
    logic        model_valid;

    typedef struct {
        logic        w;
        logic [11:0] wa;
        logic [63:0] wd;
        logic        r;
        logic [11:0] ra;
        logic [63:0] eo;
        logic        ev;
    } vec_t;

    vec_t vecs[$];

    dual_port_ram #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(12),
        .DEPTH(4096),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .wr_add(wr_add),
        .in(wdata),
        .rd(rd),
        .rd_add(rd_add),
        .out(dout),
        .rd_valid(rd_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One READY-state cycle: drive, clock, update the model, return at posedge+1.
    task automatic step(input logic w, input logic [11:0] wa, input logic [63:0] wd,
                        input logic r, input logic [11:0] ra);
        wr = w; wr_add = wa; wdata = wd; rd = r; rd_add = ra;
        @(posedge clk);
        if (r) begin
            model_out   = (BYPASS && w && (wa == ra)) ? wd : model_mem[ra];
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        if (w) model_mem[wa] = wd;
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    // Called at posedge+1 right after rst falls; counts edges until busy drops.
    task automatic wait_sweep(input string tag, input bit poke);
        int n = 0;
        if (poke) begin
            wr = 1'b1; wr_add = 12'h003; wdata = 64'hFF;
            rd = 1'b1; rd_add = 12'h003;
        end
        while (busy === 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && busy === 1'b1) begin
                check1({tag, "_sweep_rd_valid"}, rd_valid, 1'b0);
                check64({tag, "_sweep_out"}, dout, 64'h0);
            end
        end
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (n != DEPTH_C) begin
            errors++;
            $display("FAIL %s_sweep_len: got %0d cycles expected %0d", tag, n, DEPTH_C);
        end
        for (int i = 0; i < DEPTH_C; i++) model_mem[i] = 64'h0;
        model_out   = 64'h0;
        model_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        wr_add = '0; rd_add = '0; wdata = '0;
        model_out = '0; model_valid = 1'b0;
        for (int i = 0; i < DEPTH_C; i++) model_mem[i] = 64'h0;

        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h000, 64'h0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h800, 64'h0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'hFFF, 64'h0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h003, 64'h0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 12'h0A5, 64'hDEAD_BEEF_0123_4567, 1'b0, 12'h000, 64'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h0A5, 64'hDEAD_BEEF_0123_4567, 1'b1});
        vecs.push_back(vec_t'{1'b1, 12'h001, 64'h1000_0000_0000_0001, 1'b0, 12'h000, 64'hDEAD_BEEF_0123_4567, 1'b0});
        vecs.push_back(vec_t'{1'b1, 12'h002, 64'h2000_0000_0000_0002, 1'b0, 12'h000, 64'hDEAD_BEEF_0123_4567, 1'b0});
        vecs.push_back(vec_t'{1'b1, 12'h003, 64'h3000_0000_0000_0003, 1'b0, 12'h000, 64'hDEAD_BEEF_0123_4567, 1'b0});
        vecs.push_back(vec_t'{1'b1, 12'h004, 64'h4000_0000_0000_0004, 1'b0, 12'h000, 64'hDEAD_BEEF_0123_4567, 1'b0});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h001, 64'h1000_0000_0000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h002, 64'h2000_0000_0000_0002, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h003, 64'h3000_0000_0000_0003, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h004, 64'h4000_0000_0000_0004, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h4000_0000_0000_0004, 1'b0});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h4000_0000_0000_0004, 1'b0});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h4000_0000_0000_0004, 1'b0});
        vecs.push_back(vec_t'{1'b1, 12'h010, 64'h1111, 1'b0, 12'h000, 64'h4000_0000_0000_0004, 1'b0});
        vecs.push_back(vec_t'{1'b1, 12'h010, 64'h2222, 1'b1, 12'h010, COLL_EXP, 1'b1});
        vecs.push_back(vec_t'{1'b0, 12'h000, 64'h0, 1'b1, 12'h010, 64'h2222, 1'b1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("reset_busy", busy, 1'b1);
        check64("reset_out", dout, 64'h0);
        check1("reset_rd_valid", rd_valid, 1'b0);

        // Initial sweep with requests held active that must be ignored
        rst = 1'b0;
        wait_sweep("init", 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r, vecs[i].ra);
            check64($sformatf("vec%0d_out", i), dout, vecs[i].eo);
            check1($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].ev);
        end

        // Random traffic, biased to a small window so collisions occur
        for (int i = 0; i < 3000; i++) begin
            logic        w, r;
            logic [11:0] wa, ra;
            logic [63:0] wd;
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            step(w, wa, wd, r, ra);
            check64($sformatf("rand%0d_out", i), dout, model_out);
            check1($sformatf("rand%0d_rd_valid", i), rd_valid, model_valid);
        end

        // Asynchronous reset while out holds data, then a mid-sweep reset
        step(1'b1, 12'hFFF, 64'hA5A5, 1'b0, 12'h000);
        step(1'b0, 12'h000, 64'h0, 1'b1, 12'hFFF);
        check64("pre_rst_out", dout, 64'hA5A5);
        #2;
        rst = 1'b1;
        #1;
        check64("async_rst_out", dout, 64'h0);
        check1("async_rst_busy", busy, 1'b1);
        check1("async_rst_rd_valid", rd_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check1("mid_sweep_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("mid_rst_busy", busy, 1'b1);
        check64("mid_rst_out", dout, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sweep("restart", 1'b0);
        step(1'b0, 12'h000, 64'h0, 1'b1, 12'hFFF);
        check64("after_restart_fff", dout, 64'h0);
        check1("after_restart_rd_valid", rd_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
